regfile_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the 16x8 register_unit. It shares the register_unit's single load/store interface between two requesters, such as the instruction decoder and a DMA/debug port. Each requester gets a valid/grant handshake for reads and writes, plus a pipelined read-return path. It issues at most one register_unit operation per cycle and sustains one transfer per cycle.

---
 rtl/regfile_arbiter_if.sv | 58 +++++
 rtl/regfile_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the register_unit.
// With REGFILE_ARB_LOCK_EN defined, lock0/lock1 are added to the requester side.
interface regfile_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // requester 0
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  // requester 1
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
`ifdef REGFILE_ARB_LOCK_EN
  logic                  lock0;
  logic                  lock1;
`endif
  // shared read return
  logic [DATA_WIDTH-1:0] rdata;
  // register_unit side
  logic                  ru_load;
  logic                  ru_store;
  logic [ADDR_WIDTH-1:0] ru_load_addr;
  logic [ADDR_WIDTH-1:0] ru_store_addr;
  logic [DATA_WIDTH-1:0] ru_data_in;
  logic [DATA_WIDTH-1:0] ru_data_out;

  // Requesters plus register_unit environment
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
`ifdef REGFILE_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output ru_data_out,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  ru_load, ru_store, ru_load_addr, ru_store_addr, ru_data_in
  );

  // The arbiter itself
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
`ifdef REGFILE_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  ru_data_out,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output ru_load, ru_store, ru_load_addr, ru_store_addr, ru_data_in
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 16x8 register_unit.
// One command is issued per cycle; reads return 2 cycles after the handshake
// edge through a (valid, id) shift pipeline aligned with ru_data_out.
// Optional feature macro: REGFILE_ARB_LOCK_EN (lock0/lock1 pin arbitration
// to one requester for atomic read-modify-write sequences).
module regfile_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic          clock,
  input logic          reset,
  regfile_arbiter_if.slave bus
);

  localparam int NREQ = 2;

  // Requester signals gathered into vectors so both ports share one datapath
  logic [NREQ-1:0]       req_vec;
  logic [NREQ-1:0]       we_vec;
  logic [NREQ-1:0]       allow_vec;
  logic [NREQ-1:0]       gnt_vec;
  logic [NREQ-1:0]       rvalid_vec;
  logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

  assign req_vec      = {bus.req1, bus.req0};
  assign we_vec       = {bus.we1, bus.we0};
  assign addr_arr[0]  = bus.addr0;
  assign addr_arr[1]  = bus.addr1;
  assign wdata_arr[0] = bus.wdata0;
  assign wdata_arr[1] = bus.wdata1;

  // Round-robin pointer: 0 favours requester 0, 1 favours requester 1
  logic ptr_reg, ptr_next;

  // Issue stage registers
  logic                  load_reg, load_next;
  logic                  store_reg, store_next;
  logic [ADDR_WIDTH-1:0] load_addr_reg, load_addr_next;
  logic [ADDR_WIDTH-1:0] store_addr_reg, store_addr_next;
  logic [DATA_WIDTH-1:0] data_in_reg, data_in_next;

  // Read return pipeline: index 0 is the issue stage, index 1 drives rvalid
  logic [1:0] pipe_valid_reg, pipe_valid_next;
  logic [1:0] pipe_id_reg, pipe_id_next;

  // Selected command for the current transfer
  logic                  xfer;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_REQ0 = 2'd1,
    LOCK_REQ1 = 2'd2
  } lock_state_t;

  lock_state_t     lock_state_reg, lock_state_next;
  logic [NREQ-1:0] lock_vec;

  assign lock_vec = {bus.lock1, bus.lock0};

  // While locked, only the owner may compete for the grant
  always_comb begin
    allow_vec = req_vec;
    case (lock_state_reg)
      LOCK_REQ0: allow_vec = req_vec & 2'b01;
      LOCK_REQ1: allow_vec = req_vec & 2'b10;
      default:   allow_vec = req_vec;
    endcase
  end

  // Lock follows the lock bit of each transfer; unlocking transfer releases it
  always_comb begin
    lock_state_next = lock_state_reg;
    if (xfer) begin
      if (lock_vec[sel]) begin
        lock_state_next = sel ? LOCK_REQ1 : LOCK_REQ0;
      end else begin
        lock_state_next = LOCK_NONE;
      end
    end
  end

  // Lock state register
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_state_reg <= LOCK_NONE;
    end else begin
      lock_state_reg <= lock_state_next;
    end
  end
`else
  assign allow_vec = req_vec;
`endif

  // Combinational grant: sole requester wins, contention resolved by pointer
  always_comb begin
    gnt_vec = '0;
    if (&allow_vec) begin
      gnt_vec[ptr_reg] = 1'b1;
    end else begin
      gnt_vec = allow_vec;
    end
  end

  assign xfer      = |gnt_vec;
  assign sel       = gnt_vec[1];
  assign sel_we    = we_vec[sel];
  assign sel_addr  = addr_arr[sel];
  assign sel_wdata = wdata_arr[sel];

  // Next-state for pointer, issue stage and read pipeline
  always_comb begin
    ptr_next        = ptr_reg;
    load_next       = 1'b0;
    store_next      = 1'b0;
    load_addr_next  = load_addr_reg;
    store_addr_next = store_addr_reg;
    data_in_next    = data_in_reg;
    pipe_valid_next = {pipe_valid_reg[0], 1'b0};
    pipe_id_next    = {pipe_id_reg[0], 1'b0};
    if (xfer) begin
      ptr_next = ~sel;
      if (sel_we) begin
        store_next      = 1'b1;
        store_addr_next = sel_addr;
        data_in_next    = sel_wdata;
      end else begin
        load_next          = 1'b1;
        load_addr_next     = sel_addr;
        pipe_valid_next[0] = 1'b1;
        pipe_id_next[0]    = sel;
      end
    end
  end

  // State registers; reset also drops any in-flight reads
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg        <= 1'b0;
      load_reg       <= 1'b0;
      store_reg      <= 1'b0;
      load_addr_reg  <= '0;
      store_addr_reg <= '0;
      data_in_reg    <= '0;
      pipe_valid_reg <= '0;
      pipe_id_reg    <= '0;
    end else begin
      ptr_reg        <= ptr_next;
      load_reg       <= load_next;
      store_reg      <= store_next;
      load_addr_reg  <= load_addr_next;
      store_addr_reg <= store_addr_next;
      data_in_reg    <= data_in_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_id_reg    <= pipe_id_next;
    end
  end

  // Per-requester read-valid decode from the last pipeline stage
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rvalid
    assign rvalid_vec[gi] = pipe_valid_reg[1] & (pipe_id_reg[1] == 1'(gi));
  end

  assign bus.gnt0          = gnt_vec[0];
  assign bus.gnt1          = gnt_vec[1];
  assign bus.rvalid0       = rvalid_vec[0];
  assign bus.rvalid1       = rvalid_vec[1];
  assign bus.rdata         = bus.ru_data_out;
  assign bus.ru_load       = load_reg;
  assign bus.ru_store      = store_reg;
  assign bus.ru_load_addr  = load_addr_reg;
  assign bus.ru_store_addr = store_addr_reg;
  assign bus.ru_data_in    = data_in_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: table-driven grant/issue vectors,
// hand-written reset and lock sequences, and a read-return scoreboard.
module tb_regfile_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural register_unit: store and registered load on the same edge
  logic [7:0] ru_mem [16];
  always @(posedge clock) begin
    if (bus.ru_store) ru_mem[bus.ru_store_addr] <= bus.ru_data_in;
    if (bus.ru_load)  bus.ru_data_out <= ru_mem[bus.ru_load_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected read returns
  typedef struct {
    bit         id;
    logic [7:0] data;
    int         due;
  } sb_t;
  sb_t        sb[$];
  logic [7:0] shadow [16];

  // Compare read returns every cycle, then record the handshake of the next edge
  always @(negedge clock) begin
    sb_t        e;
    bit         have;
    logic [1:0] exp_rv;
    logic [1:0] act_rv;
    if (mon_en) begin
      have   = 1'b0;
      exp_rv = 2'b00;
      act_rv = {bus.rvalid1, bus.rvalid0};
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e      = sb.pop_front();
        have   = 1'b1;
        exp_rv = e.id ? 2'b10 : 2'b01;
      end
      chk("rvalid", 32'(act_rv), 32'(exp_rv));
      if (have && act_rv == exp_rv) begin
        chk("rdata", 32'(bus.rdata), 32'(e.data));
        $display("read  req%0d data=0x%02h cycle %0d", e.id, bus.rdata, cyc);
      end
      if (reset) begin
        sb.delete();
      end else if (bus.req0 && bus.gnt0) begin
        if (bus.we0) shadow[bus.addr0] = bus.wdata0;
        else sb.push_back('{id: 1'b0, data: shadow[bus.addr0], due: cyc + 2});
      end else if (bus.req1 && bus.gnt1) begin
        if (bus.we1) shadow[bus.addr1] = bus.wdata1;
        else sb.push_back('{id: 1'b1, data: shadow[bus.addr1], due: cyc + 2});
      end
    end
  end

  typedef struct packed {
    bit       r0; bit w0; bit [3:0] a0; bit [7:0] d0; bit l0;
    bit       r1; bit w1; bit [3:0] a1; bit [7:0] d1; bit l1;
    bit       g0; bit g1;
    bit       ld; bit st; bit [3:0] la; bit [3:0] sa; bit [7:0] di;
  } row_t;

  function automatic row_t mk(input int r0, w0, a0, d0, r1, w1, a1, d1,
                              g0, g1, ld, st, la, sa, di,
                              input int l0 = 0, input int l1 = 0);
    row_t r;
    r.r0 = 1'(r0); r.w0 = 1'(w0); r.a0 = 4'(a0); r.d0 = 8'(d0); r.l0 = 1'(l0);
    r.r1 = 1'(r1); r.w1 = 1'(w1); r.a1 = 4'(a1); r.d1 = 8'(d1); r.l1 = 1'(l1);
    r.g0 = 1'(g0); r.g1 = 1'(g1);
    r.ld = 1'(ld); r.st = 1'(st); r.la = 4'(la); r.sa = 4'(sa); r.di = 8'(di);
    return r;
  endfunction

  // Apply one row: drive, check grants mid-cycle, check issue after the edge
  task automatic run_row(input row_t r, input string tag);
    bus.req0 = r.r0; bus.we0 = r.w0; bus.addr0 = r.a0; bus.wdata0 = r.d0;
    bus.req1 = r.r1; bus.we1 = r.w1; bus.addr1 = r.a1; bus.wdata1 = r.d1;
`ifdef REGFILE_ARB_LOCK_EN
    bus.lock0 = r.l0; bus.lock1 = r.l1;
`endif
    @(negedge clock);
    chk({tag, ".gnt0"}, 32'(bus.gnt0), 32'(r.g0));
    chk({tag, ".gnt1"}, 32'(bus.gnt1), 32'(r.g1));
    @(posedge clock); #1;
    chk({tag, ".ru_load"},       32'(bus.ru_load),       32'(r.ld));
    chk({tag, ".ru_store"},      32'(bus.ru_store),      32'(r.st));
    chk({tag, ".ru_load_addr"},  32'(bus.ru_load_addr),  32'(r.la));
    chk({tag, ".ru_store_addr"}, 32'(bus.ru_store_addr), 32'(r.sa));
    chk({tag, ".ru_data_in"},    32'(bus.ru_data_in),    32'(r.di));
    $display("row %s gnt=%b%b load=%b store=%b la=%0d sa=%0d di=0x%02h",
             tag, bus.gnt1, bus.gnt0, bus.ru_load, bus.ru_store,
             bus.ru_load_addr, bus.ru_store_addr, bus.ru_data_in);
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef REGFILE_ARB_LOCK_EN
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif
  endtask

  // One-cycle reset, then verify every registered output is cleared
  task automatic pulse_reset(input string tag);
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    chk({tag, ".ru_load"},       32'(bus.ru_load),       0);
    chk({tag, ".ru_store"},      32'(bus.ru_store),      0);
    chk({tag, ".ru_load_addr"},  32'(bus.ru_load_addr),  0);
    chk({tag, ".ru_store_addr"}, 32'(bus.ru_store_addr), 0);
    chk({tag, ".ru_data_in"},    32'(bus.ru_data_in),    0);
    chk({tag, ".rvalid"},        32'({bus.rvalid1, bus.rvalid0}), 0);
    $display("reset %s applied at cycle %0d", tag, cyc);
    reset = 1'b0;
  endtask

  row_t tbl [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ru_mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    // write/read-after-write, contention, back-to-back, idle
    tbl[0]  = mk(1,1,3,'hA5, 0,0,0,0,     1,0, 0,1,0,3,'hA5);
    tbl[1]  = mk(0,0,0,0,    1,0,3,0,     0,1, 1,0,3,3,'hA5);
    tbl[2]  = mk(0,0,0,0,    0,0,0,0,     0,0, 0,0,3,3,'hA5);
    tbl[3]  = mk(1,1,1,'h11, 1,1,2,'h22,  1,0, 0,1,3,1,'h11);
    tbl[4]  = mk(0,0,0,0,    1,1,2,'h22,  0,1, 0,1,3,2,'h22);
    tbl[5]  = mk(1,0,1,0,    1,0,2,0,     1,0, 1,0,1,2,'h22);
    tbl[6]  = mk(1,0,1,0,    1,0,2,0,     0,1, 1,0,2,2,'h22);
    tbl[7]  = mk(1,0,1,0,    1,0,2,0,     1,0, 1,0,1,2,'h22);
    tbl[8]  = mk(1,0,1,0,    1,0,2,0,     0,1, 1,0,2,2,'h22);
    tbl[9]  = mk(1,0,1,0,    1,0,2,0,     1,0, 1,0,1,2,'h22);
    tbl[10] = mk(1,0,1,0,    1,0,2,0,     0,1, 1,0,2,2,'h22);
    tbl[11] = mk(1,1,5,'h3C, 0,0,0,0,     1,0, 0,1,2,5,'h3C);
    tbl[12] = mk(1,0,5,0,    0,0,0,0,     1,0, 1,0,5,5,'h3C);
    tbl[13] = mk(0,0,0,0,    0,0,0,0,     0,0, 0,0,5,5,'h3C);
    tbl[14] = mk(0,0,0,0,    0,0,0,0,     0,0, 0,0,5,5,'h3C);
    tbl[15] = mk(0,0,0,0,    0,0,0,0,     0,0, 0,0,5,5,'h3C);
    tbl[16] = mk(0,0,0,0,    0,0,0,0,     0,0, 0,0,5,5,'h3C);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("init.ru_load",       32'(bus.ru_load),       0);
    chk("init.ru_store",      32'(bus.ru_store),      0);
    chk("init.ru_load_addr",  32'(bus.ru_load_addr),  0);
    chk("init.ru_store_addr", 32'(bus.ru_store_addr), 0);
    chk("init.ru_data_in",    32'(bus.ru_data_in),    0);
    chk("init.rvalid",        32'({bus.rvalid1, bus.rvalid0}), 0);
    chk("init.gnt",           32'({bus.gnt1, bus.gnt0}), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 17; i++) run_row(tbl[i], $sformatf("t%0d", i));

    // Read handshake on req1 immediately followed by reset: read must vanish
    run_row(mk(0,0,0,0, 1,0,4,0, 0,1, 1,0,4,5,'h3C), "rst_rd");
    pulse_reset("rst_mid");
    run_row(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0), "rst_idle0");
    run_row(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0), "rst_idle1");
    // Pointer restored to requester 0; register contents survive reset
    run_row(mk(1,0,1,0, 1,0,2,0, 1,0, 1,0,1,0,0), "rst_both");
    run_row(mk(0,0,0,0, 1,0,2,0, 0,1, 1,0,2,0,0), "rst_r1");
    run_row(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,2,0,0), "rst_idle2");
    run_row(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,2,0,0), "rst_idle3");

`ifdef REGFILE_ARB_LOCK_EN
    // Locked read of addr 7 by req0 keeps req1 out until the unlocking write
    pulse_reset("lock_rst");
    run_row(mk(1,0,7,0,    1,0,2,0, 1,0, 1,0,7,0,0,    1,0), "lock_rd");
    run_row(mk(0,0,0,0,    1,0,2,0, 0,0, 0,0,7,0,0,    0,0), "lock_hold");
    run_row(mk(1,1,7,'h77, 1,0,2,0, 1,0, 0,1,7,7,'h77, 0,0), "lock_wr");
    run_row(mk(0,0,0,0,    1,0,2,0, 0,1, 1,0,2,7,'h77, 0,0), "lock_rel");
    run_row(mk(0,0,0,0,    0,0,0,0, 0,0, 0,0,2,7,'h77, 0,0), "lock_idle0");
    run_row(mk(0,0,0,0,    0,0,0,0, 0,0, 0,0,2,7,'h77, 0,0), "lock_idle1");
`endif

    @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
